// File: rtl/motion_sequencer_if.sv
// motion_sequencer_if
//  Host command bus for the motion sequencer: a valid/ready strobe carrying one
//  move command (axis index + pulse count).
//  cmd_valid  host -> seq   command strobe
//  cmd_ready  seq -> host   command queue can accept
//  cmd_axis   host -> seq   axis index 0..5
//  cmd_pulses host -> seq   pulse count 1..1023
interface motion_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_axis;
    logic [9:0] cmd_pulses;

    modport master (output cmd_valid, output cmd_axis, output cmd_pulses, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_axis, input cmd_pulses, output cmd_ready);
endinterface

// File: rtl/motion_sequencer.sv
// motion_sequencer
//  Command scheduler in front of the 6-axis stepper pulse generator. Move commands
//  are queued in a small FIFO and issued one at a time once homing is complete.
//  Each move is tracked through start and finish, then the generator inputs are
//  parked at 0/0 for a gap so a repeated identical command is seen as a change.
// Ports
//  sysclk, rst    clock, asynchronous active-high reset
//  cmd            host command bus (slave side)
//  abort          flush queue and park the generator
//  pg_init_flag   per-axis homing-done flags;  pg_busy  generator busy
//  pg_motor       one-hot axis select;          pg_pulse_num  pulse count
//  homed          registered AND of the homing flags
//  seq_busy       a move is in flight or parking
//  done_pulse     1-cycle strobe on move completion
//  err_cmd        1-cycle strobe, illegal command dropped
//  err_timeout    sticky, generator never started a move
//  fifo_count     commands queued
module motion_sequencer #(
    parameter int DEPTH         = 4,
    parameter int GAP_CYCLES    = 8,
    parameter int START_TIMEOUT = 255
) (
    input  logic                       sysclk,
    input  logic                       rst,
    motion_sequencer_if.slave          cmd,
    input  logic                       abort,
    input  logic [5:0]                 pg_init_flag,
    input  logic                       pg_busy,
    output logic [5:0]                 pg_motor,
    output logic [9:0]                 pg_pulse_num,
    output logic                       homed,
    output logic                       seq_busy,
    output logic                       done_pulse,
    output logic                       err_cmd,
    output logic                       err_timeout,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef struct packed {
        logic [2:0] axis;
        logic [9:0] pulses;
    } cmd_t;

    typedef enum logic [2:0] {WAIT_HOME, IDLE, WAIT_START, WAIT_DONE, PARK} state_t;

    state_t          state;
    cmd_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gap;
    cmd_t            head;
    logic            accept, legal, push, pop;

    assign cmd.cmd_ready = (count < CW'(DEPTH));
    assign fifo_count    = count;
    assign seq_busy      = (state != IDLE) && (state != WAIT_HOME);
    assign head          = mem[rd_ptr];

    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign legal  = (cmd.cmd_axis <= 3'd5) && (cmd.cmd_pulses != 10'd0);
    // abort flushes the queue, so it also swallows a same-cycle push
    assign push   = accept && legal && !abort;
    assign pop    = (state == IDLE) && homed && (count != '0) && !abort;

    // Storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge sysclk) begin
        if (push)
            mem[wr_ptr] <= cmd_t'{axis: cmd.cmd_axis, pulses: cmd.cmd_pulses};
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cmd <= 1'b0;
            homed   <= 1'b0;
        end else begin
            homed   <= &pg_init_flag;
            err_cmd <= accept && !legal;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_HOME;
            pg_motor     <= '0;
            pg_pulse_num <= '0;
            done_pulse   <= 1'b0;
            err_timeout  <= 1'b0;
            timer        <= '0;
            gap          <= '0;
        end else begin
            done_pulse <= 1'b0;
            if (abort)
                err_timeout <= 1'b0;
            if (abort && state != WAIT_HOME) begin
                state        <= PARK;
                pg_motor     <= '0;
                pg_pulse_num <= '0;
                gap          <= '0;
            end else begin
                case (state)
                    WAIT_HOME: if (homed) state <= IDLE;
                    IDLE: begin
                        if (!homed)
                            state <= WAIT_HOME;
                        else if (pop) begin
                            pg_motor     <= 6'd1 << head.axis;
                            pg_pulse_num <= head.pulses;
                            timer        <= '0;
                            state        <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (pg_busy)
                            state <= WAIT_DONE;
                        else if (timer == TW'(START_TIMEOUT - 1)) begin
                            // generator never acknowledged: give up on this move
                            err_timeout  <= 1'b1;
                            pg_motor     <= '0;
                            pg_pulse_num <= '0;
                            gap          <= '0;
                            state        <= PARK;
                        end else
                            timer <= timer + 1'b1;
                    end
                    WAIT_DONE: begin
                        if (!pg_busy) begin
                            done_pulse   <= 1'b1;
                            pg_motor     <= '0;
                            pg_pulse_num <= '0;
                            gap          <= '0;
                            state        <= PARK;
                        end
                    end
                    PARK: begin
                        // hold the 0/0 gap; leave only once the generator is idle
                        if (gap == GW'(GAP_CYCLES - 1)) begin
                            if (!pg_busy) state <= homed ? IDLE : WAIT_HOME;
                        end else
                            gap <= gap + 1'b1;
                    end
                    default: state <= WAIT_HOME;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer
//  Scoreboard bench: every accepted legal command pushes its expected generator
//  setting; a monitor pops and compares on each issue seen at pg_motor.
module tb_motion_sequencer;
    localparam int DEPTH = 4;
    localparam int GAP   = 8;
    localparam int TMO   = 255;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       pg_busy = 1'b0;
    logic [5:0] pg_init_flag = 6'd0;
    logic [5:0] pg_motor;
    logic [9:0] pg_pulse_num;
    logic       homed, seq_busy, done_pulse, err_cmd, err_timeout;
    logic [2:0] fifo_count;

    motion_sequencer_if cmd_bus();

    motion_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
        .sysclk(sysclk), .rst(rst), .cmd(cmd_bus), .abort(abort),
        .pg_init_flag(pg_init_flag), .pg_busy(pg_busy), .pg_motor(pg_motor),
        .pg_pulse_num(pg_pulse_num), .homed(homed), .seq_busy(seq_busy),
        .done_pulse(done_pulse), .err_cmd(err_cmd), .err_timeout(err_timeout),
        .fifo_count(fifo_count)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [5:0] motor;
        logic [9:0] pulses;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0, n_bad = 0;
    int   model_cnt = 0, done_cnt = 0, errc_cnt = 0, zrun = 0;
    bit   had_issue = 0;
    logic [5:0] prev_motor = 6'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // issue / strobe monitor
    initial forever begin
        @(negedge sysclk);
        if (rst) begin
            had_issue  = 0;
            zrun       = 0;
            prev_motor = 6'd0;
        end else begin
            if (done_pulse) done_cnt++;
            if (err_cmd)    errc_cnt++;
            if (pg_motor != 6'd0 && prev_motor == 6'd0) begin
                if (exp_q.size() == 0)
                    chk("issue_unexpected", 32'(pg_motor), 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_motor", 32'(pg_motor), 32'(mon_e.motor));
                    chk("issue_pulses", 32'(pg_pulse_num), 32'(mon_e.pulses));
                    model_cnt--;
                end
                if (had_issue) chk("park_gap", 32'(zrun >= GAP), 32'd1);
                had_issue = 1;
                zrun      = 0;
            end else if (pg_motor == 6'd0)
                zrun++;
            prev_motor = pg_motor;
        end
    end

    task automatic push(input logic [2:0] ax, input logic [9:0] pn);
        bit   rdy;
        exp_t x;
        @(negedge sysclk); #1;
        rdy = (model_cnt < DEPTH);
        chk("cmd_ready", 32'(cmd_bus.cmd_ready), 32'(rdy));
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_axis   = ax;
        cmd_bus.cmd_pulses = pn;
        @(posedge sysclk); #1;
        cmd_bus.cmd_valid = 1'b0;
        if (rdy && ax <= 3'd5 && pn != 10'd0) begin
            x.motor  = 6'd1 << ax;
            x.pulses = pn;
            exp_q.push_back(x);
            model_cnt++;
        end
    endtask

    task automatic wait_issue();
        for (int i = 0; i < 100 && pg_motor == 6'd0; i++) @(negedge sysclk);
        chk("issue_seen", 32'(pg_motor != 6'd0), 32'd1);
    endtask

    // generator model for one move: start after dly cycles, stay busy len cycles
    task automatic run_move(input int dly, input int len);
        wait_issue();
        repeat (dly) @(posedge sysclk);
        #1 pg_busy = 1'b1;
        repeat (len) @(posedge sysclk);
        #1 pg_busy = 1'b0;
        for (int i = 0; i < 20 && !done_pulse; i++) @(negedge sysclk);
        chk("done_seen", 32'(done_pulse), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && seq_busy; i++) @(negedge sysclk);
        chk("back_idle", 32'(seq_busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_axis   = 3'd0;
        cmd_bus.cmd_pulses = 10'd0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_motor", 32'(pg_motor), 32'd0);
        chk("rst_pulses", 32'(pg_pulse_num), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_tmo", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        @(negedge sysclk);
        chk("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(seq_busy), 32'd0);

        // held in WAIT_HOME until homing completes
        push(3'd2, 10'd100);
        repeat (5) @(negedge sysclk);
        chk("home_hold_motor", 32'(pg_motor), 32'd0);
        chk("home_hold_count", 32'(fifo_count), 32'd1);
        chk("home_hold_homed", 32'(homed), 32'd0);

        pg_init_flag = 6'h3F;
        d0 = done_cnt;
        run_move(2, 3);
        chk("homed_up", 32'(homed), 32'd1);
        wait_idle();
        chk("one_done", 32'(done_cnt - d0), 32'd1);
        chk("parked_pulses", 32'(pg_pulse_num), 32'd0);

        // identical command twice must be issued twice with a park gap
        d0 = done_cnt;
        push(3'd1, 10'd5);
        push(3'd1, 10'd5);
        run_move(1, 2);
        run_move(0, 4);
        wait_idle();
        chk("two_done", 32'(done_cnt - d0), 32'd2);

        // fill the queue while unhomed: fifth command is refused
        pg_init_flag = 6'h00;
        repeat (4) @(negedge sysclk);
        push(3'd0, 10'd1);
        push(3'd3, 10'd1023);
        push(3'd5, 10'd7);
        push(3'd4, 10'd200);
        push(3'd2, 10'd9);
        @(negedge sysclk); #1;
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        d0 = done_cnt;
        pg_init_flag = 6'h3F;
        run_move(1, 1);
        run_move(3, 2);
        run_move(0, 1);
        run_move(2, 5);
        wait_idle();
        chk("four_done", 32'(done_cnt - d0), 32'd4);

        // illegal commands, then a start timeout
        d0 = errc_cnt;
        push(3'd6, 10'd10);
        push(3'd0, 10'd0);
        repeat (2) @(negedge sysclk);
        chk("err_cmd_cnt", 32'(errc_cnt - d0), 32'd2);
        chk("err_cmd_count", 32'(fifo_count), 32'd0);
        d0 = done_cnt;
        push(3'd3, 10'd50);
        wait_issue();
        repeat (TMO - 1) @(negedge sysclk);
        chk("tmo_early", 32'(err_timeout), 32'd0);
        @(negedge sysclk);
        chk("tmo_hit", 32'(err_timeout), 32'd1);
        chk("tmo_park", 32'(pg_motor), 32'd0);
        wait_idle();
        chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
        chk("tmo_sticky", 32'(err_timeout), 32'd1);

        // abort mid-move with three commands queued
        d0 = done_cnt;
        push(3'd0, 10'd11);
        wait_issue();
        #1 pg_busy = 1'b1;
        push(3'd1, 10'd1);
        push(3'd2, 10'd2);
        push(3'd3, 10'd3);
        @(negedge sysclk); #1;
        chk("abort_pre_count", 32'(fifo_count), 32'd3);
        abort = 1'b1;
        @(posedge sysclk); #1;
        abort = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        @(negedge sysclk);
        chk("abort_count", 32'(fifo_count), 32'd0);
        chk("abort_motor", 32'(pg_motor), 32'd0);
        chk("abort_pulses", 32'(pg_pulse_num), 32'd0);
        chk("abort_tmo_clr", 32'(err_timeout), 32'd0);
        repeat (2) @(posedge sysclk);
        #1 pg_busy = 1'b0;
        repeat (15) @(negedge sysclk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle", 32'(seq_busy), 32'd0);

        // reset in the middle of a move
        push(3'd4, 10'd300);
        wait_issue();
        #1 pg_busy = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_motor", 32'(pg_motor), 32'd0);
        chk("midrst_pulses", 32'(pg_pulse_num), 32'd0);
        chk("midrst_busy", 32'(seq_busy), 32'd0);
        @(posedge sysclk); #1;
        rst = 1'b0;
        pg_busy = 1'b0;
        repeat (4) @(negedge sysclk);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_homed", 32'(homed), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
